// File: rtl/shift_word_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_word_pkg
//  Description : Shared types and helpers for the shift_word_register family.
//  Revision    : 1.0 - initial release
// ============================================================================

package shift_word_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bit-counter width for a word of the given length, never narrower than 1.
    function automatic int CountWidth(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/word_hold_reg.sv
`default_nettype none
// ============================================================================
//  Module      : word_hold_reg
//  Description : One-entry valid/ready holding register with sticky overrun
//                flag; a word completed while the previous one is unclaimed
//                is dropped.
//  Revision    : 1.0 - initial release
// ============================================================================

module word_hold_reg
    import shift_word_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic [DATA_W-1:0] capture_data_i,
    input  logic              ready_i,
    input  logic              overrun_clr_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              overrun_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              overrun_q;
    logic              w_drop;

    // A capture coinciding with ready replaces the consumed word.
    assign w_drop = capture_i && valid_q && !ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (capture_i && !w_drop) begin
                data_q  <= capture_data_i;
                valid_q <= 1'b1;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end

            if (w_drop) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign overrun_o = overrun_q;

endmodule

`default_nettype wire

// File: rtl/shift_word_register.sv
`default_nettype none
// ============================================================================
//  Module      : shift_word_register
//  Description : Full-duplex serial shifter with word framing, one-entry tx
//                buffer and valid/ready rx word output.
//                Optional: define SHIFT_WORD_REGISTER_PARITY_EN to add the
//                even-parity output word_parity.
//  Revision    : 1.0 - initial release
// ============================================================================

module shift_word_register
    import shift_word_pkg::*;
#(
    parameter int   WIDTH       = 8,
    parameter logic RESET_VALUE = 1'b0,
    parameter bit   MSB_FIRST   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             flush,
    input  logic             serial_in,
    output logic             serial_out,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_data,
    output logic             busy,
    output logic             overrun,
    input  logic             overrun_clr
`ifdef SHIFT_WORD_REGISTER_PARITY_EN
    ,
    output logic             word_parity
`endif
);

    localparam int                 C_CNT_W      = CountWidth(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST       = C_CNT_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_ONE        = C_CNT_W'(1);
    localparam logic [WIDTH-1:0]   C_RESET_WORD = {WIDTH{RESET_VALUE}};

    state_e             state_q;
    logic [C_CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   tx_data_q;
    logic               tx_full_q;

    logic [WIDTH-1:0]   w_shifted;
    logic               w_boundary;
    logic               w_idle_load;
    logic               w_load_fire;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted  = {shreg_q[WIDTH-2:0], serial_in};
            assign serial_out = shreg_q[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted  = {serial_in, shreg_q[WIDTH-1:1]};
            assign serial_out = shreg_q[0];
        end
    endgenerate

    assign load_ready  = !tx_full_q && !rst;
    assign w_load_fire = load_valid && load_ready;
    assign w_boundary  = shift_en && !flush && (state_q == SHIFT) && (cnt_q == C_LAST);
    assign w_idle_load = !flush && !shift_en && (state_q == IDLE) && tx_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= C_RESET_WORD;
            tx_full_q <= 1'b0;
            tx_data_q <= '0;
        end else begin
            // Acceptance needs an empty buffer and draining needs a full one,
            // so these never collide with the drains below.
            if (w_load_fire) begin
                tx_full_q <= 1'b1;
                tx_data_q <= load_data;
            end

            if (flush) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else if (shift_en) begin
                if (w_boundary) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    if (tx_full_q) begin
                        shreg_q   <= tx_data_q;
                        tx_full_q <= 1'b0;
                    end else begin
                        shreg_q <= w_shifted;
                    end
                end else begin
                    state_q <= SHIFT;
                    cnt_q   <= cnt_q + C_ONE;
                    shreg_q <= w_shifted;
                end
            end else if (w_idle_load) begin
                shreg_q   <= tx_data_q;
                tx_full_q <= 1'b0;
            end
        end
    end

    assign busy = (state_q == SHIFT);

`ifdef SHIFT_WORD_REGISTER_PARITY_EN
    localparam int C_HOLD_W = WIDTH + 1;
`else
    localparam int C_HOLD_W = WIDTH;
`endif

    logic [C_HOLD_W-1:0] w_hold_in;
    logic [C_HOLD_W-1:0] w_hold_out;

`ifdef SHIFT_WORD_REGISTER_PARITY_EN
    assign w_hold_in   = {^w_shifted, w_shifted};
    assign word_data   = w_hold_out[WIDTH-1:0];
    assign word_parity = w_hold_out[WIDTH];
`else
    assign w_hold_in   = w_shifted;
    assign word_data   = w_hold_out;
`endif

    word_hold_reg #(
        .DATA_W (C_HOLD_W)
    ) u_hold (
        .clk            (clk),
        .rst            (rst),
        .capture_i      (w_boundary),
        .capture_data_i (w_hold_in),
        .ready_i        (word_ready),
        .overrun_clr_i  (overrun_clr),
        .valid_o        (word_valid),
        .data_o         (w_hold_out),
        .overrun_o      (overrun)
    );

endmodule

`default_nettype wire

// File: tb/tb_shift_word_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_word_register
//  Description : Self-checking bench for shift_word_register (LSB- and
//                MSB-first instances driven by the same stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_shift_word_register;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, shift_en, flush, serial_in, load_valid, word_ready, overrun_clr;
    logic [W-1:0] load_data;

    logic         so [2];
    logic         lr [2];
    logic         wv [2];
    logic         bz [2];
    logic         ov [2];
    logic [W-1:0] wd [2];
`ifdef SHIFT_WORD_REGISTER_PARITY_EN
    logic         par [2];
`endif

    shift_word_register #(.WIDTH(W), .RESET_VALUE(1'b0), .MSB_FIRST(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .shift_en(shift_en), .flush(flush), .serial_in(serial_in),
        .serial_out(so[0]), .load_valid(load_valid), .load_ready(lr[0]), .load_data(load_data),
        .word_valid(wv[0]), .word_ready(word_ready), .word_data(wd[0]),
        .busy(bz[0]), .overrun(ov[0]), .overrun_clr(overrun_clr)
`ifdef SHIFT_WORD_REGISTER_PARITY_EN
        , .word_parity(par[0])
`endif
    );

    shift_word_register #(.WIDTH(W), .RESET_VALUE(1'b0), .MSB_FIRST(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .shift_en(shift_en), .flush(flush), .serial_in(serial_in),
        .serial_out(so[1]), .load_valid(load_valid), .load_ready(lr[1]), .load_data(load_data),
        .word_valid(wv[1]), .word_ready(word_ready), .word_data(wd[1]),
        .busy(bz[1]), .overrun(ov[1]), .overrun_clr(overrun_clr)
`ifdef SHIFT_WORD_REGISTER_PARITY_EN
        , .word_parity(par[1])
`endif
    );

    // Reference model: bit stream queues, index 0 = LSB-first, 1 = MSB-first.
    bit           m_out [2][$];
    bit           m_rx  [2][$];
    bit           m_txf [2];
    logic [W-1:0] m_txd [2];
    bit           m_hv  [2];
    logic [W-1:0] m_hd  [2];
    bit           m_ov  [2];
    bit           m_ok = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int m, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, m, got, exp, $time);
        end
    endtask

    task automatic load_out(input int m, input logic [W-1:0] w);
        m_out[m].delete();
        for (int i = 0; i < W; i++) m_out[m].push_back(m == 0 ? w[i] : w[W-1-i]);
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit           acc;
            bit           done;
            logic [W-1:0] word;
            if (rst) begin
                load_out(m, '0);
                m_rx[m].delete();
                m_txf[m] = 1'b0; m_txd[m] = '0;
                m_hv[m]  = 1'b0; m_hd[m]  = '0; m_ov[m] = 1'b0;
                continue;
            end
            acc  = load_valid && !m_txf[m];
            done = 1'b0;
            word = '0;
            if (flush) begin
                m_rx[m].delete();
            end else if (shift_en) begin
                void'(m_out[m].pop_front());
                m_out[m].push_back(serial_in);
                m_rx[m].push_back(serial_in);
                if (m_rx[m].size() == W) begin
                    for (int i = 0; i < W; i++) word[m == 0 ? i : W-1-i] = m_rx[m][i];
                    done = 1'b1;
                    m_rx[m].delete();
                    if (m_txf[m]) begin load_out(m, m_txd[m]); m_txf[m] = 1'b0; end
                end
            end else if (m_rx[m].size() == 0 && m_txf[m]) begin
                load_out(m, m_txd[m]);
                m_txf[m] = 1'b0;
            end
            if (overrun_clr) m_ov[m] = 1'b0;
            if (done) begin
                if (m_hv[m] && !word_ready) m_ov[m] = 1'b1;
                else begin m_hd[m] = word; m_hv[m] = 1'b1; end
            end else if (m_hv[m] && word_ready) begin
                m_hv[m] = 1'b0;
            end
            if (acc) begin m_txf[m] = 1'b1; m_txd[m] = load_data; end
        end
        m_ok = 1'b1;
    endtask

    task automatic compare_all();
        if (!m_ok) return;
        for (int m = 0; m < 2; m++) begin
            check("serial_out", m, so[m], m_out[m][0]);
            check("load_ready", m, lr[m], (!m_txf[m] && !rst));
            check("word_valid", m, wv[m], m_hv[m]);
            check("word_data",  m, wd[m], m_hd[m]);
            check("busy",       m, bz[m], (m_rx[m].size() != 0));
            check("overrun",    m, ov[m], m_ov[m]);
`ifdef SHIFT_WORD_REGISTER_PARITY_EN
            check("word_parity", m, par[m], ^m_hd[m]);
`endif
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; shift_en = 1'b0; flush = 1'b0; serial_in = 1'b0;
        load_valid = 1'b0; load_data = '0; word_ready = 1'b1; overrun_clr = 1'b0;
    endtask

    typedef struct {
        logic         se;
        logic         si;
        logic         e_busy;
        logic         e_wv;
        logic [W-1:0] e_wd;
    } vec_t;

    vec_t tv [9];
    logic seq1 [8];
    logic seq2 [8];

    initial begin
        int           nwords;
        logic [W-1:0] got_word;
        logic [15:0]  stream;

        seq1 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        seq2 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 8; k++)
            tv[k] = '{1'b1, seq1[k], (k < 7), (k == 7), (k == 7) ? 8'h4D : 8'h00};
        tv[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h4D};

        // Reset
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        for (int m = 0; m < 2; m++) begin
            check("rst_busy", m, bz[m], 0);
            check("rst_word_valid", m, wv[m], 0);
            check("rst_word_data", m, wd[m], 0);
            check("rst_overrun", m, ov[m], 0);
            check("rst_serial_out", m, so[m], 0);
            check("rst_load_ready", m, lr[m], 0);
        end
        rst = 1'b0;

        // LSB-first word 0x4D, table driven
        for (int k = 0; k < 9; k++) begin
            shift_en = tv[k].se; serial_in = tv[k].si;
            tick();
            check("t1_busy", 0, bz[0], tv[k].e_busy);
            check("t1_word_valid", 0, wv[0], tv[k].e_wv);
            check("t1_word_data", 0, wd[0], tv[k].e_wd);
        end

        // MSB-first transmit of 0xA5
        idle_inputs();
        load_valid = 1'b1; load_data = 8'hA5;
        tick();
        load_valid = 1'b0;
        tick();
        shift_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t2_serial_out", 1, so[1], seq2[k]);
            tick();
        end
        shift_en = 1'b0;
        check("t2_word_valid", 1, wv[1], 1);
        check("t2_word_data", 1, wd[1], 8'h00);
        tick();

        // Back-to-back streaming of 0x3C then 0xC3
        load_valid = 1'b1; load_data = 8'h3C;
        tick();
        load_data = 8'hC3;
        check("t3_ready_full", 0, lr[0], 0);
        tick();
        check("t3_ready_word1", 0, lr[0], 1);
        shift_en = 1'b1;
        stream = 16'hC33C;
        for (int k = 0; k < 16; k++) begin
            check("t3_serial_out", 0, so[0], stream[k]);
            tick();
            load_valid = 1'b0;
        end
        shift_en = 1'b0;
        tick();

        // Overrun: 0x11 held, 0x22 dropped
        word_ready = 1'b0;
        shift_en = 1'b1;
        stream = 16'h2211;
        for (int k = 0; k < 16; k++) begin
            serial_in = stream[k];
            tick();
        end
        shift_en = 1'b0;
        check("t4_word_valid", 0, wv[0], 1);
        check("t4_word_data", 0, wd[0], 8'h11);
        check("t4_overrun", 0, ov[0], 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("t4_overrun_clr", 0, ov[0], 0);
        check("t4_word_kept", 0, wd[0], 8'h11);
        word_ready = 1'b1;
        tick();

        // Flush after 3 shifts (flush beats shift_en), then a full 0xFF word
        nwords = 0; got_word = '0;
        for (int k = 0; k < 13; k++) begin
            shift_en  = (k < 12);
            flush     = (k == 3);
            serial_in = (k > 3);
            tick();
            if (wv[0]) begin nwords++; got_word = wd[0]; end
        end
        flush = 1'b0;
        check("t5_word_count", 0, nwords, 1);
        check("t5_word_data", 0, got_word, 8'hFF);

        // Reset mid-word with the tx buffer full
        idle_inputs();
        load_valid = 1'b1; load_data = 8'hA5; shift_en = 1'b1; serial_in = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("t6_busy_before", 0, bz[0], 1);
        shift_en = 1'b0; rst = 1'b1;
        tick();
        for (int m = 0; m < 2; m++) begin
            check("t6_busy", m, bz[m], 0);
            check("t6_load_ready_rst", m, lr[m], 0);
            check("t6_serial_out", m, so[m], 0);
            check("t6_word_valid", m, wv[m], 0);
            check("t6_word_data", m, wd[m], 0);
        end
        rst = 1'b0;
        #1;
        check("t6_load_ready", 0, lr[0], 1);
        tick();
        check("t6_no_stale_load", 0, so[0], 0);
        check("t6_no_stale_load", 1, so[1], 0);

        // Randomised traffic against the model
        for (int c = 0; c < 2000; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            shift_en    = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            serial_in   = $urandom_range(0, 1);
            load_valid  = $urandom_range(0, 1);
            load_data   = W'($urandom);
            word_ready  = $urandom_range(0, 1);
            overrun_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle_inputs();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
